// File: rtl/pipeline_scheduler_pkg.sv
// Shared scheduler constants and FSM state encoding.
// Used by pipeline_scheduler and reg_scoreboard.
package pipeline_scheduler_pkg;

  localparam int REG_COUNT_L2 = 4;
  localparam int PC_REG = 15;

  typedef enum logic [1:0] {
    S_RUNNING  = 2'd0,
    S_HAZARD   = 2'd1,
    S_PC_FLUSH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pipeline_scheduler_reg_scoreboard.sv
// In-flight destination register scoreboard.
// Set wins over clear; the PC register is never tracked.
module reg_scoreboard
  import pipeline_scheduler_pkg::*;
#(
  parameter int AW = REG_COUNT_L2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic                 rd_pend1,
  output logic                 rd_pend2,
  output logic [(1<<AW)-1:0]   mask
);

  localparam int N = 1 << AW;
  localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);

  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_addr != PC_IDX)
      set_vec[set_addr] = 1'b1;
    if (clr_en && clr_addr != PC_IDX)
      clr_vec[clr_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mask <= '0;
    else
      mask <= (mask & ~clr_vec) | set_vec;
  end

  assign rd_pend1 = mask[rd_addr1];
  assign rd_pend2 = mask[rd_addr2];

endmodule

// File: rtl/pipeline_scheduler.sv
// Pipeline sequencer: stage enables, RAW stall and PC-write squash.
// Optional perf counters under SCHED_PERF_COUNTERS_EN.
module pipeline_scheduler
  import pipeline_scheduler_pkg::*;
#(
  parameter int REG_COUNT_L2 = pipeline_scheduler_pkg::REG_COUNT_L2,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fetcher_ready,
  input  logic                          decoder_ready,
  input  logic                          executor_ready,
  input  logic                          memaccessor_ready,
  input  logic                          flush_for_pc,
  input  logic [1:0]                    dec_src_valid,
  input  logic [REG_COUNT_L2-1:0]       dec_src_addr1,
  input  logic [REG_COUNT_L2-1:0]       dec_src_addr2,
  input  logic                          dec_dst_valid,
  input  logic [REG_COUNT_L2-1:0]       dec_dst_addr,
  input  logic                          wb_retire,
  input  logic [REG_COUNT_L2-1:0]       wb_retire_addr,
  output logic                          fetcher_enable,
  output logic                          decoder_enable,
  output logic                          executor_enable,
  output logic                          memaccessor_enable,
  output logic                          regfilewriter_enable,
  output logic                          frontend_hold,
  output logic [1:0]                    sched_state,
  output logic [(1<<REG_COUNT_L2)-1:0]  pending_mask
`ifdef SCHED_PERF_COUNTERS_EN
  ,
  output logic [PERF_WIDTH-1:0]         stall_count,
  output logic [PERF_WIDTH-1:0]         flush_count,
  output logic [PERF_WIDTH-1:0]         retire_count
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  sched_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic          pend1;
  logic          pend2;
  logic          hazard;
  logic          squash;
  logic          stall;
  logic          claim;

  reg_scoreboard #(.AW(REG_COUNT_L2)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (claim),
    .set_addr (dec_dst_addr),
    .clr_en   (wb_retire),
    .clr_addr (wb_retire_addr),
    .rd_addr1 (dec_src_addr1),
    .rd_addr2 (dec_src_addr2),
    .rd_pend1 (pend1),
    .rd_pend2 (pend2),
    .mask     (pending_mask)
  );

  assign hazard = (dec_src_valid[0] & pend1)
                | (dec_src_valid[1] & pend2);
  assign squash = flush_for_pc | (state_q == S_PC_FLUSH);
  assign stall  = ~squash & hazard & decoder_ready;
  assign claim  = executor_enable & decoder_ready & dec_dst_valid;

  always_comb begin
    fetcher_enable       = 1'b0;
    decoder_enable       = 1'b0;
    executor_enable      = 1'b0;
    memaccessor_enable   = 1'b0;
    regfilewriter_enable = 1'b0;
    frontend_hold        = 1'b0;
    if (!reset) begin
      memaccessor_enable   = executor_ready;
      regfilewriter_enable = memaccessor_ready;
      unique case (1'b1)
        squash: ;
        stall:  frontend_hold = 1'b1;
        default: begin
          fetcher_enable  = 1'b1;
          decoder_enable  = fetcher_ready;
          executor_enable = decoder_ready;
        end
      endcase
    end
  end

  // A flush of one cycle needs no PC_FLUSH residency at all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUNNING;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_PC_FLUSH: begin
          if (cnt_q <= CW'(1)) begin
            state_q <= S_RUNNING;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          if (flush_for_pc) begin
            cnt_q   <= CW'(FLUSH_CYCLES - 1);
            state_q <= (FLUSH_CYCLES > 1) ? S_PC_FLUSH : S_RUNNING;
          end else begin
            state_q <= stall ? S_HAZARD : S_RUNNING;
          end
        end
      endcase
    end
  end

  assign sched_state = state_q;

`ifdef SCHED_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count  <= '0;
      flush_count  <= '0;
      retire_count <= '0;
    end else begin
      if (stall && !(&stall_count))
        stall_count <= stall_count + 1'b1;
      if (flush_for_pc && !(&flush_count))
        flush_count <= flush_count + 1'b1;
      if (wb_retire && !(&retire_count))
        retire_count <= retire_count + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_reflush: assert property (@(posedge clk) disable iff (reset)
    !((state_q == S_PC_FLUSH) && flush_for_pc));
`endif

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Scoreboard-driven bench for pipeline_scheduler.
// Perf-counter test runs only with SCHED_PERF_COUNTERS_EN.
module tb_pipeline_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic fetcher_ready, decoder_ready, executor_ready, memaccessor_ready;
  logic flush_for_pc;
  logic [1:0] dec_src_valid;
  logic [3:0] dec_src_addr1, dec_src_addr2;
  logic dec_dst_valid;
  logic [3:0] dec_dst_addr;
  logic wb_retire;
  logic [3:0] wb_retire_addr;
  logic fetcher_enable, decoder_enable, executor_enable;
  logic memaccessor_enable, regfilewriter_enable, frontend_hold;
  logic [1:0] sched_state;
  logic [15:0] pending_mask;
`ifdef SCHED_PERF_COUNTERS_EN
  logic [3:0] stall_count, flush_count, retire_count;
`endif

  int n_tests = 0;
  int n_fail = 0;

  pipeline_scheduler #(
    .REG_COUNT_L2(4), .FLUSH_CYCLES(2), .PERF_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .fetcher_ready(fetcher_ready),
    .decoder_ready(decoder_ready),
    .executor_ready(executor_ready),
    .memaccessor_ready(memaccessor_ready),
    .flush_for_pc(flush_for_pc),
    .dec_src_valid(dec_src_valid),
    .dec_src_addr1(dec_src_addr1),
    .dec_src_addr2(dec_src_addr2),
    .dec_dst_valid(dec_dst_valid),
    .dec_dst_addr(dec_dst_addr),
    .wb_retire(wb_retire),
    .wb_retire_addr(wb_retire_addr),
    .fetcher_enable(fetcher_enable),
    .decoder_enable(decoder_enable),
    .executor_enable(executor_enable),
    .memaccessor_enable(memaccessor_enable),
    .regfilewriter_enable(regfilewriter_enable),
    .frontend_hold(frontend_hold),
    .sched_state(sched_state),
    .pending_mask(pending_mask)
`ifdef SCHED_PERF_COUNTERS_EN
    ,
    .stall_count(stall_count),
    .flush_count(flush_count),
    .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rdy;
    logic [1:0]  sv;
    logic [3:0]  a1, a2;
    logic        dv;
    logic [3:0]  da;
    logic        wr;
    logic [3:0]  wa;
    logic        fl;
    logic [5:0]  en;
    logic [15:0] mask;
    logic [1:0]  st;
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(
    logic [3:0] rdy, logic [1:0] sv, logic [3:0] a1, logic [3:0] a2,
    logic dv, logic [3:0] da, logic wr, logic [3:0] wa, logic fl,
    logic [5:0] en, logic [15:0] mask, logic [1:0] st);
    vec_t v;
    v.rdy = rdy; v.sv = sv; v.a1 = a1; v.a2 = a2;
    v.dv = dv; v.da = da; v.wr = wr; v.wa = wa; v.fl = fl;
    v.en = en; v.mask = mask; v.st = st;
    return v;
  endfunction

  function automatic logic [5:0] en_obs();
    return {fetcher_enable, decoder_enable, executor_enable,
            memaccessor_enable, regfilewriter_enable, frontend_hold};
  endfunction

  task automatic drive(input vec_t v);
    {fetcher_ready, decoder_ready,
     executor_ready, memaccessor_ready} = v.rdy;
    dec_src_valid = v.sv;
    dec_src_addr1 = v.a1;
    dec_src_addr2 = v.a2;
    dec_dst_valid = v.dv;
    dec_dst_addr = v.da;
    wb_retire = v.wr;
    wb_retire_addr = v.wa;
    flush_for_pc = v.fl;
    exp_q.push_back(v);
  endtask

  task automatic idle();
    vec_t v;
    v = mk(4'hF, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0,
           6'b0, 16'h0, 2'd0);
    drive(v);
    void'(exp_q.pop_back());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    n_tests++;
    if (en_obs() !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_en got %b want %b", en_obs(), 6'b0);
    end
    n_tests++;
    if (sched_state !== 2'd0 || pending_mask !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got %0d/%h want 0/0000",
               sched_state, pending_mask);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_chain();
    vec_t t[$];
    vec_t e;
    t.push_back(mk(4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 16'h0000, 0));
    t.push_back(mk(4'hA, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b110100, 16'h0000, 0));
    t.push_back(mk(4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b101010, 16'h0000, 0));
    t.push_back(mk(4'hB, 2'b00, 0, 0, 1, 2, 0, 0, 0, 6'b110110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 1, 9, 0, 0, 0, 6'b111110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b10, 0, 9, 0, 0, 0, 0, 0, 6'b000111, 16'h0200, 0));
    t.push_back(mk(4'hB, 2'b10, 0, 9, 0, 0, 0, 0, 0, 6'b110110, 16'h0200, 1));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 1, 9, 0, 6'b111110, 16'h0200, 0));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b111110, 16'h0000, 0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (en_obs() !== e.en || pending_mask !== e.mask
          || sched_state !== e.st) begin
        n_fail++;
        $display("FAIL chain row %0d got %b/%h/%0d want %b/%h/%0d", i,
                 en_obs(), pending_mask, sched_state, e.en, e.mask, e.st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw_stall();
    vec_t t[$];
    vec_t e;
    t.push_back(mk(4'hF, 2'b00, 0, 0, 1, 3, 0, 0, 0, 6'b111110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b01, 3, 0, 0, 0, 0, 0, 0, 6'b000111, 16'h0008, 0));
    t.push_back(mk(4'hF, 2'b01, 3, 0, 0, 0, 0, 0, 0, 6'b000111, 16'h0008, 1));
    t.push_back(mk(4'hF, 2'b01, 3, 0, 0, 0, 1, 3, 0, 6'b000111, 16'h0008, 1));
    t.push_back(mk(4'hF, 2'b01, 3, 0, 0, 0, 0, 0, 0, 6'b111110, 16'h0000, 1));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b111110, 16'h0000, 0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (en_obs() !== e.en || pending_mask !== e.mask
          || sched_state !== e.st) begin
        n_fail++;
        $display("FAIL raw row %0d got %b/%h/%0d want %b/%h/%0d", i,
                 en_obs(), pending_mask, sched_state, e.en, e.mask, e.st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_over_hazard();
    vec_t t[$];
    vec_t e;
    t.push_back(mk(4'hF, 2'b00, 0, 0, 1, 7, 0, 0, 0, 6'b111110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b01, 7, 0, 0, 0, 0, 0, 1, 6'b000110, 16'h0080, 0));
    t.push_back(mk(4'hF, 2'b01, 7, 0, 0, 0, 0, 0, 0, 6'b000110, 16'h0080, 2));
    t.push_back(mk(4'hF, 2'b01, 7, 0, 0, 0, 0, 0, 0, 6'b000111, 16'h0080, 0));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 1, 7, 0, 6'b111110, 16'h0080, 1));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b111110, 16'h0000, 0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (en_obs() !== e.en || pending_mask !== e.mask
          || sched_state !== e.st) begin
        n_fail++;
        $display("FAIL flush row %0d got %b/%h/%0d want %b/%h/%0d", i,
                 en_obs(), pending_mask, sched_state, e.en, e.mask, e.st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_set_wins_and_r15();
    vec_t t[$];
    vec_t e;
    t.push_back(mk(4'hF, 2'b00, 0, 0, 1, 5, 1, 5, 0, 6'b111110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6'b111110, 16'h0020, 0));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 0, 0, 1, 5, 0, 6'b111110, 16'h0020, 0));
    t.push_back(mk(4'hF, 2'b00, 0, 0, 1, 15, 0, 0, 0, 6'b111110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b11, 15, 15, 0, 0, 1, 15, 0, 6'b111110, 16'h0000, 0));
    t.push_back(mk(4'hF, 2'b11, 15, 15, 0, 0, 0, 0, 0, 6'b111110, 16'h0000, 0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (en_obs() !== e.en || pending_mask !== e.mask
          || sched_state !== e.st) begin
        n_fail++;
        $display("FAIL setclr row %0d got %b/%h/%0d want %b/%h/%0d", i,
                 en_obs(), pending_mask, sched_state, e.en, e.mask, e.st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    vec_t v;
    v = mk(4'hF, 2'b00, 0, 0, 1, 4, 0, 0, 0, 6'b111110, 16'h0000, 0);
    drive(v);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    v = mk(4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 1, 6'b000110, 16'h0010, 0);
    drive(v);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    idle();
    n_tests++;
    if (sched_state !== 2'd2 || pending_mask !== 16'h0010) begin
      n_fail++;
      $display("FAIL mid_flush_pre got %0d/%h want 2/0010",
               sched_state, pending_mask);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (en_obs() !== 6'b0 || sched_state !== 2'd0
        || pending_mask !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_flush_reset got %b/%0d/%h want 000000/0/0000",
               en_obs(), sched_state, pending_mask);
    end
    #2;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (en_obs() !== 6'b111110 || sched_state !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_flush_resume got %b/%0d want 111110/0",
               en_obs(), sched_state);
    end
    @(posedge clk); #1;
  endtask

`ifdef SCHED_PERF_COUNTERS_EN
  task automatic test_perf_saturate();
    vec_t v;
    reset = 1'b1;
    idle();
    #2;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_count !== 4'h0) begin
      n_fail++;
      $display("FAIL perf_reset got %h want 0", stall_count);
    end
    @(posedge clk); #1;
    v = mk(4'hF, 2'b00, 0, 0, 1, 1, 0, 0, 0, 6'b111110, 16'h0, 0);
    drive(v);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    v = mk(4'hF, 2'b01, 1, 0, 0, 0, 0, 0, 0, 6'b000111, 16'h2, 0);
    drive(v);
    void'(exp_q.pop_back());
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (stall_count !== 4'hF) begin
      n_fail++;
      $display("FAIL perf_sat got %h want f", stall_count);
    end
    v = mk(4'hF, 2'b00, 0, 0, 0, 0, 1, 1, 0, 6'b111110, 16'h2, 0);
    drive(v);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    n_tests++;
    if (retire_count !== 4'h1 || pending_mask !== 16'h0) begin
      n_fail++;
      $display("FAIL perf_retire got %h/%h want 1/0000",
               retire_count, pending_mask);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_chain();
    test_raw_stall();
    test_flush_over_hazard();
    test_set_wins_and_r15();
    test_reset_mid_flush();
`ifdef SCHED_PERF_COUNTERS_EN
    test_perf_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
